// File: rtl/lsu_dccm_req_arb_pkg.sv
// Shared LSU definitions: access size codes, the DC1 arbiter state and the
// DC1 address-check packet layout.
package lsu_dccm_req_arb_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    CORE_PRI  = 2'd0,
    DMA_FORCE = 2'd1,
    DMA_BEAT2 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        dma;
    logic        store;
    logic        by;
    logic        half;
    logic        word;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } lsu_pkt_t;

endpackage

// File: rtl/lsu_dccm_req_arb_pkt_build.sv
// Size one-hot decode and inclusive end address for one DC1 request.
module lsu_pkt_build
  import lsu_dccm_req_arb_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  sz,
  output logic        by,
  output logic        half,
  output logic        word,
  output logic [31:0] end_addr
);

  logic [31:0] offset;

  always_comb begin
    by   = (sz == SZ_BYTE);
    half = (sz == SZ_HALF);
    // Dwords never reach here split-free; treat the code as a word if it does.
    word = (sz == SZ_WORD) || (sz == SZ_DWORD);
    case (sz)
      SZ_BYTE: offset = 32'd0;
      SZ_HALF: offset = 32'd1;
      default: offset = 32'd3;
    endcase
    end_addr = addr + offset;
  end

endmodule

// File: rtl/lsu_dccm_req_arb.sv
// Core/DMA arbiter for the single DC1 access slot: builds the DC1 packet,
// splits DMA dwords into two word beats and forces DMA priority on starvation.
module lsu_dccm_req_arb
  import lsu_dccm_req_arb_pkg::*;
#(
  parameter int DMA_STALL_THRESH = 8,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             core_req,
  input  logic [31:0]      core_addr,
  input  logic [1:0]       core_sz,
  input  logic             core_wr,
  output logic             core_gnt,
  output logic             core_stall,
  input  logic             dma_req,
  input  logic [31:0]      dma_addr,
  input  logic [1:0]       dma_sz,
  input  logic             dma_wr,
  output logic             dma_ready,
  output logic             pkt_valid_dc1,
  output logic             pkt_dma_dc1,
  output logic             pkt_store_dc1,
  output logic             pkt_by_dc1,
  output logic             pkt_half_dc1,
  output logic             pkt_word_dc1,
  output logic [31:0]      start_addr_dc1,
  output logic [31:0]      end_addr_dc1,
  output arb_state_t       arb_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(DMA_STALL_THRESH - 1);

  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      beat2_addr;
  logic             run, dma_gnt, beat1, dma_dword;
  logic [31:0]      req_addr;
  logic [1:0]       req_sz;
  logic             req_wr, req_dma;
  logic             b_by, b_half, b_word;
  logic [31:0]      b_end;
  lsu_pkt_t         pkt;

  assign run       = rst_l & ~freeze;
  assign dma_dword = (dma_sz == SZ_DWORD);

  always_comb begin
    state_nxt = arb_state;
    cnt_nxt   = stall_cnt;
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    dma_ready = 1'b0;
    beat1     = 1'b0;
    req_dma   = 1'b0;
    req_addr  = core_addr;
    req_sz    = core_sz;
    req_wr    = core_wr;
    case (arb_state)
      CORE_PRI: begin
        if (core_req) begin
          core_gnt = 1'b1;
        end else if (dma_req) begin
          dma_gnt   = 1'b1;
          dma_ready = ~dma_dword;
          beat1     = dma_dword;
          if (dma_dword) state_nxt = DMA_BEAT2;
        end
        // Only a DMA request that loses to the core counts toward starvation.
        if (dma_req && core_req) begin
          if (stall_cnt == THRESH_M1) begin
            cnt_nxt   = '0;
            state_nxt = DMA_FORCE;
          end else begin
            cnt_nxt = stall_cnt + 1'b1;
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      DMA_FORCE: begin
        cnt_nxt   = '0;
        state_nxt = CORE_PRI;
        if (dma_req) begin
          dma_gnt   = 1'b1;
          dma_ready = ~dma_dword;
          beat1     = dma_dword;
          if (dma_dword) state_nxt = DMA_BEAT2;
        end
      end
      DMA_BEAT2: begin
        cnt_nxt   = '0;
        state_nxt = CORE_PRI;
        dma_gnt   = 1'b1;
        dma_ready = 1'b1;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = CORE_PRI;
      end
    endcase
    if (dma_gnt) begin
      req_dma  = 1'b1;
      req_wr   = dma_wr;
      req_addr = (arb_state == DMA_BEAT2) ? beat2_addr : dma_addr;
      req_sz   = (dma_dword || arb_state == DMA_BEAT2) ? SZ_WORD : dma_sz;
    end
    if (!run) begin
      core_gnt  = 1'b0;
      dma_gnt   = 1'b0;
      dma_ready = 1'b0;
      beat1     = 1'b0;
    end
  end

  assign core_stall = rst_l & (arb_state != CORE_PRI);

  lsu_pkt_build u_pkt_build (
    .addr     (req_addr),
    .sz       (req_sz),
    .by       (b_by),
    .half     (b_half),
    .word     (b_word),
    .end_addr (b_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      arb_state  <= CORE_PRI;
      stall_cnt  <= '0;
      beat2_addr <= '0;
      pkt        <= '0;
    end else if (!freeze) begin
      arb_state <= state_nxt;
      stall_cnt <= cnt_nxt;
      if (beat1) beat2_addr <= dma_addr + 32'd4;
      pkt.valid <= core_gnt | dma_gnt;
      if (core_gnt | dma_gnt) begin
        pkt.dma        <= req_dma;
        pkt.store      <= req_wr;
        pkt.by         <= b_by;
        pkt.half       <= b_half;
        pkt.word       <= b_word;
        pkt.start_addr <= req_addr;
        pkt.end_addr   <= b_end;
      end
    end
  end

  assign pkt_valid_dc1  = pkt.valid;
  assign pkt_dma_dc1    = pkt.dma;
  assign pkt_store_dc1  = pkt.store;
  assign pkt_by_dc1     = pkt.by;
  assign pkt_half_dc1   = pkt.half;
  assign pkt_word_dc1   = pkt.word;
  assign start_addr_dc1 = pkt.start_addr;
  assign end_addr_dc1   = pkt.end_addr;

endmodule
